// File: rtl/db_req_sched.sv
// Request scheduler: queues {op, key, value} requests and issues them one at a time to a db controller,
// holding each issue stable for ISSUE_GAP cycles. Define DB_REQ_STATS_EN to enable the statistics counters.
module db_req_sched #(
    parameter int HASH_SIZE  = 32,
    parameter int KEY_SIZE   = 96,
    parameter int VAL_SIZE   = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int ISSUE_GAP  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [KEY_SIZE-1:0]   req_key,
    input  logic [VAL_SIZE-1:0]   req_value,
    output logic                  db_valid,
    output logic [3:0]            db_op,
    output logic [HASH_SIZE-1:0]  db_hash,
    output logic [KEY_SIZE-1:0]   db_key,
    output logic [VAL_SIZE-1:0]   db_value,
    output logic [31:0]           stat_issued,
    output logic [31:0]           stat_stall
);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int NSLICE = KEY_SIZE / 32;
    localparam int CW     = $clog2(ISSUE_GAP + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t                state_reg, state_next;
    logic [CW-1:0]         hold_cnt_reg, hold_cnt_next;
    logic [AW:0]           wr_ptr_reg, rd_ptr_reg;
    logic [3:0]            mem_op    [FIFO_DEPTH];
    logic [KEY_SIZE-1:0]   mem_key   [FIFO_DEPTH];
    logic [VAL_SIZE-1:0]   mem_value [FIFO_DEPTH];
    logic                  full, empty, push, pop;
    logic [KEY_SIZE-1:0]   head_key;
    logic [31:0]           key_slice [NSLICE];
    logic [31:0]           head_hash;

    // Extra pointer bit tells full (MSBs differ) from empty (pointers equal).
    assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign req_ready = !rst && !full;
    assign push      = req_valid && req_ready;
    assign db_valid  = (state_reg == ISSUE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_op[wr_ptr_reg[AW-1:0]]    <= req_op;
            mem_key[wr_ptr_reg[AW-1:0]]   <= req_key;
            mem_value[wr_ptr_reg[AW-1:0]] <= req_value;
        end
    end

    assign head_key = mem_key[rd_ptr_reg[AW-1:0]];

    generate
        for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
            assign key_slice[gi] = head_key[gi*32 +: 32];
        end
    endgenerate

    always_comb begin
        head_hash = '0;
        for (int i = 0; i < NSLICE; i++) begin
            head_hash = head_hash ^ key_slice[i];
        end
    end

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        pop           = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                hold_cnt_next = CW'(ISSUE_GAP);
                state_next    = HOLD;
            end
            HOLD: begin
                hold_cnt_next = hold_cnt_reg - 1'b1;
                if (hold_cnt_reg == CW'(1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Issue outputs only change on a pop, so they stay put through ISSUE and HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            db_op        <= '0;
            db_key       <= '0;
            db_value     <= '0;
            db_hash      <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                db_op      <= mem_op[rd_ptr_reg[AW-1:0]];
                db_key     <= head_key;
                db_value   <= mem_value[rd_ptr_reg[AW-1:0]];
                db_hash    <= HASH_SIZE'(head_hash);
            end
        end
    end

`ifdef DB_REQ_STATS_EN
    logic [31:0] stat_issued_reg, stat_stall_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued_reg <= '0;
            stat_stall_reg  <= '0;
        end else begin
            if (state_reg == ISSUE)      stat_issued_reg <= stat_issued_reg + 1'b1;
            if (req_valid && !req_ready) stat_stall_reg  <= stat_stall_reg + 1'b1;
        end
    end

    assign stat_issued = stat_issued_reg;
    assign stat_stall  = stat_stall_reg;
`else
    assign stat_issued = '0;
    assign stat_stall  = '0;
`endif

endmodule
